squash_arbiter: RTL and testbench
=================================

SQUASH_ARBITER -- requirements
Module: squash_arbiter

Interface
REQ-001: Parameter p_num_units, default 2, number of squash-publishing execute units (range 1..8).
REQ-002: Parameter p_seq_num_bits, default 5, sequence-number width.
REQ-003: Reset rst, synchronous, active-high; clock clk.
REQ-004: clk  input  1  clock.
REQ-005: rst  input  1  synchronous active-high reset.
REQ-006: in_val  input  p_num_units  per-unit squash request valid.
REQ-007: in_target  input  32*p_num_units  per-unit redirect PC; unit i occupies bits [32i+31:32i].
REQ-008: in_seq_num  input  p_seq_num_bits*p_num_units  per-unit squashing instruction seq number, packed as for in_target.
REQ-009: head_seq_num  input  p_seq_num_bits  seq number of the oldest in-flight instruction, used as the age base.
REQ-010: commit_val  input  1  an instruction commits this cycle.
REQ-011: commit_seq_num  input  p_seq_num_bits  seq number of the committing instruction.
REQ-012: out_val  output  1  merged squash notification valid.
REQ-013: out_target  output  32  redirect PC of the selected squash.
REQ-014: out_seq_num  output  p_seq_num_bits  seq number of the selected squash.

Function
REQ-015: Age of seq s SHALL be (s - head_seq_num) mod 2^p_seq_num_bits; smaller age means older.
REQ-016: Among eligible valid inputs, the oldest SHALL be selected; on equal age, the lowest unit index wins.
REQ-017: The selection SHALL be registered: inputs sampled at edge t drive out_* during cycle t+1 (latency 1); out_val is a single-cycle pulse per selection.
REQ-018: If no input is eligible, out_val SHALL be 0 in the next cycle and out_target/out_seq_num SHALL hold their previous values.
REQ-019: No backpressure; out_val SHALL NOT depend on any ready signal.
REQ-020: Tracker state: act (1 bit) and act_seq (p_seq_num_bits), shadowing the most recent emitted squash.
REQ-021: When out_val=1, act SHALL be set to 1 and act_seq to out_seq_num at the next edge.
REQ-022: When act=1, commit_val=1 and commit_seq_num==act_seq, act SHALL be cleared at the next edge, unless REQ-021 applies in that cycle, in which case REQ-021 wins.
REQ-023: Reference seq = out_seq_num if out_val=1, else act_seq if act=1, else none.
REQ-024: An input with no reference is eligible; with a reference (filter enabled) it is eligible only if its age is strictly less than the reference age.
REQ-025: Age comparisons SHALL use the current-cycle head_seq_num for all operands, including wrap-around (e.g. 5-bit: head=30, seq 1 is younger than seq 31).

Reset
REQ-026: While rst=1 at an edge: out_val, out_target, out_seq_num, act and act_seq SHALL all become 0; in_val is ignored in that cycle.
REQ-027: A reset asserted while out_val=1 or act=1 SHALL discard that state; the first post-reset cycle has out_val=0.

Configuration
REQ-028: Macro SQUASH_ARBITER_FILTER_EN: when defined, REQ-020..REQ-024 filtering is compiled in.
REQ-029: Without SQUASH_ARBITER_FILTER_EN, the tracker SHALL be absent; every valid input is eligible and only oldest-wins selection with latency 1 applies.

Verification
REQ-030: Reset, then in_val=2'b11, seq {u0=4,u1=2}, head=0 -> next cycle out_val=1, out_seq_num=2, out_target=unit1 target.
REQ-031: Wrap: head=30, u0 seq=1, u1 seq=31 both valid -> out_seq_num=31.
REQ-032: Equal seq on both units -> unit 0's target is selected.
REQ-033: Filter on: squash seq=6 emitted; next cycle u0 seq=9 (head=0) -> out_val=0; u1 seq=3 -> out_val=1, out_seq_num=3.
REQ-034: Filter on: act_seq=6, commit_val=1, commit_seq_num=6 -> act clears; next input seq=9 -> emitted with out_val=1.
REQ-035: rst asserted in the cycle out_val=1 -> next cycle out_val=0, act=0; a seq=9 input one cycle after deassertion is emitted.

Source files
------------

// File: rtl/squash_arbiter.sv
// Merges per-unit squash requests into one registered redirect, oldest first.
// Optional SQUASH_ARBITER_FILTER_EN drops requests no older than the last squash.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_val              : per-unit squash request valid
//   in_target           : per-unit redirect PC, unit i at [32i+31:32i]
//   in_seq_num          : per-unit squashing seq number, packed like in_target
//   head_seq_num        : oldest in-flight seq number, base for age compares
//   commit_val          : an instruction commits this cycle
//   commit_seq_num      : seq number of the committing instruction
//   out_val             : one-cycle pulse per selected squash
//   out_target          : redirect PC of the selected squash
//   out_seq_num         : seq number of the selected squash
module squash_arbiter #(
  parameter int p_num_units    = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_units-1:0]                in_val,
  input  logic [32*p_num_units-1:0]             in_target,
  input  logic [p_seq_num_bits*p_num_units-1:0] in_seq_num,
  input  logic [p_seq_num_bits-1:0]             head_seq_num,
  input  logic                                  commit_val,
  input  logic [p_seq_num_bits-1:0]             commit_seq_num,
  output logic                                  out_val,
  output logic [31:0]                           out_target,
  output logic [p_seq_num_bits-1:0]             out_seq_num
);

  localparam int SW = p_seq_num_bits;

  logic [p_num_units-1:0][SW-1:0] age;
  logic [p_num_units-1:0]         elig;
  logic                           sel_val;
  logic [SW-1:0]                  sel_age;
  logic [31:0]                    sel_target;
  logic [SW-1:0]                  sel_seq;

  // Age relative to the current head; modular subtraction handles wrap.
  always_comb begin
    age = '0;
    for (int i = 0; i < p_num_units; i++) begin
      age[i] = in_seq_num[SW*i +: SW] - head_seq_num;
    end
  end

`ifdef SQUASH_ARBITER_FILTER_EN
  logic          act;
  logic [SW-1:0] act_seq;
  logic          ref_val;
  logic [SW-1:0] ref_seq;
  logic [SW-1:0] ref_age;

  // The squash being emitted now shadows the tracked one.
  assign ref_val = out_val | act;
  assign ref_seq = out_val ? out_seq_num : act_seq;
  assign ref_age = ref_seq - head_seq_num;

  always_comb begin
    elig = '0;
    for (int i = 0; i < p_num_units; i++) begin
      elig[i] = in_val[i] & (~ref_val | (age[i] < ref_age));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act     <= 1'b0;
      act_seq <= '0;
    end else if (out_val) begin
      act     <= 1'b1;
      act_seq <= out_seq_num;
    end else if (act && commit_val
                 && commit_seq_num == act_seq) begin
      act     <= 1'b0;
    end
  end
`else
  logic unused;

  assign elig   = in_val;
  assign unused = ^{commit_val, commit_seq_num};
`endif

  // Strict less-than keeps the lowest index on equal age.
  always_comb begin
    sel_val    = 1'b0;
    sel_age    = '0;
    sel_target = '0;
    sel_seq    = '0;
    for (int i = 0; i < p_num_units; i++) begin
      if (elig[i] && (!sel_val || age[i] < sel_age)) begin
        sel_val    = 1'b1;
        sel_age    = age[i];
        sel_target = in_target[32*i +: 32];
        sel_seq    = in_seq_num[SW*i +: SW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_val     <= 1'b0;
      out_target  <= '0;
      out_seq_num <= '0;
    end else begin
      out_val <= sel_val;
      if (sel_val) begin
        out_target  <= sel_target;
        out_seq_num <= sel_seq;
      end
    end
  end

endmodule

// File: tb/tb_squash_arbiter.sv
// Randomised and directed bench for squash_arbiter.
// Reference model works on integer ages and tracks filter state when enabled.
module tb_squash_arbiter;
  localparam int NU = 2;
  localparam int SW = 5;
  localparam int NS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NU-1:0] in_val;
  logic [32*NU-1:0] in_target;
  logic [SW*NU-1:0] in_seq_num;
  logic [SW-1:0] head_seq_num;
  logic          commit_val;
  logic [SW-1:0] commit_seq_num;
  logic          out_val;
  logic [31:0]   out_target;
  logic [SW-1:0] out_seq_num;

  always #5 clk = ~clk;

  squash_arbiter #(
    .p_num_units(NU),
    .p_seq_num_bits(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_val(in_val),
    .in_target(in_target),
    .in_seq_num(in_seq_num),
    .head_seq_num(head_seq_num),
    .commit_val(commit_val),
    .commit_seq_num(commit_seq_num),
    .out_val(out_val),
    .out_target(out_target),
    .out_seq_num(out_seq_num)
  );

  int checks = 0;
  int errors = 0;

  bit            m_val;
  logic [31:0]   m_tgt;
  logic [SW-1:0] m_seq;
  bit            m_act;
  logic [SW-1:0] m_act_seq;

  function automatic int age_of(int s, int h);
    return ((s - h) % NS + NS) % NS;
  endfunction

  // Advance one clock, updating the reference model from current inputs.
  task automatic tick();
    bit nv;
    int bi;
    int ba;
    bit has_ref;
    int ra;
    int a;
    nv = 0; bi = 0; ba = NS;
    has_ref = 0; ra = 0;
`ifdef SQUASH_ARBITER_FILTER_EN
    if (m_val) begin
      has_ref = 1; ra = age_of(int'(m_seq), int'(head_seq_num));
    end else if (m_act) begin
      has_ref = 1; ra = age_of(int'(m_act_seq), int'(head_seq_num));
    end
`endif
    for (int i = 0; i < NU; i++) begin
      if (in_val[i]) begin
        a = age_of(int'(in_seq_num[i*SW +: SW]), int'(head_seq_num));
        if (!(has_ref && a >= ra) && a < ba) begin
          ba = a; bi = i; nv = 1;
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      m_val = 0; m_tgt = '0; m_seq = '0;
      m_act = 0; m_act_seq = '0;
    end else begin
      if (m_val) begin
        m_act = 1; m_act_seq = m_seq;
      end else if (m_act && commit_val && commit_seq_num == m_act_seq) begin
        m_act = 0;
      end
      m_val = nv;
      if (nv) begin
        m_tgt = in_target[bi*32 +: 32];
        m_seq = in_seq_num[bi*SW +: SW];
      end
    end
    #1;
  endtask

  task automatic drive(input logic [NU-1:0] v, input logic [31:0] t0,
                       input int s0, input logic [31:0] t1, input int s1,
                       input int h);
    in_val = v;
    in_target = {t1, t0};
    in_seq_num = {SW'(s1), SW'(s0)};
    head_seq_num = SW'(h);
  endtask

  task automatic do_reset();
    rst = 1; commit_val = 0; commit_seq_num = '0;
    drive(2'b11, 32'hdead_0000, 3, 32'hdead_1111, 4, 0);
    tick();
    rst = 0;
    drive(2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL reset_val got %0b want 0", out_val);
    end
    checks++;
    if (out_target !== 32'h0) begin
      errors++; $display("FAIL reset_target got %h want 0", out_target);
    end
    checks++;
    if (out_seq_num !== 5'd0) begin
      errors++; $display("FAIL reset_seq got %0d want 0", out_seq_num);
    end
  endtask

  task automatic test_oldest();
    do_reset();
    drive(2'b11, 32'ha000_0000, 4, 32'hb000_0001, 2, 0);
    tick();
    checks++;
    if (out_val !== 1'b1 || out_seq_num !== 5'd2
        || out_target !== 32'hb000_0001) begin
      errors++;
      $display("FAIL oldest got v=%0b s=%0d t=%h want v=1 s=2 t=b0000001",
               out_val, out_seq_num, out_target);
    end
    drive(2'b00, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL pulse got %0b want 0", out_val);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(2'b11, 32'h1111_0000, 1, 32'h2222_0001, 31, 30);
    tick();
    checks++;
    if (out_val !== 1'b1 || out_seq_num !== 5'd31
        || out_target !== 32'h2222_0001) begin
      errors++;
      $display("FAIL wrap got v=%0b s=%0d t=%h want v=1 s=31 t=22220001",
               out_val, out_seq_num, out_target);
    end
  endtask

  task automatic test_tie();
    do_reset();
    drive(2'b11, 32'h3333_0000, 7, 32'h4444_0001, 7, 5);
    tick();
    checks++;
    if (out_val !== 1'b1 || out_seq_num !== 5'd7
        || out_target !== 32'h3333_0000) begin
      errors++;
      $display("FAIL tie got v=%0b s=%0d t=%h want v=1 s=7 t=33330000",
               out_val, out_seq_num, out_target);
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(2'b10, 32'h0, 0, 32'h5555_0001, 5, 0);
    tick();
    drive(2'b00, 32'h0, 0, 32'h6666_0001, 1, 0);
    tick();
    checks++;
    if (out_val !== 1'b0 || out_seq_num !== 5'd5
        || out_target !== 32'h5555_0001) begin
      errors++;
      $display("FAIL hold got v=%0b s=%0d t=%h want v=0 s=5 t=55550001",
               out_val, out_seq_num, out_target);
    end
  endtask

`ifdef SQUASH_ARBITER_FILTER_EN
  task automatic test_filter();
    do_reset();
    drive(2'b01, 32'h7000_0000, 6, 32'h0, 0, 0);
    tick();
    drive(2'b01, 32'h7000_0009, 9, 32'h0, 0, 0);
    tick();
    checks++;
    if (out_val !== 1'b0) begin
      errors++; $display("FAIL filter_younger got v=%0b want 0", out_val);
    end
    drive(2'b10, 32'h0, 0, 32'h7000_0003, 3, 0);
    tick();
    checks++;
    if (out_val !== 1'b1 || out_seq_num !== 5'd3) begin
      errors++;
      $display("FAIL filter_older got v=%0b s=%0d want v=1 s=3",
               out_val, out_seq_num);
    end
  endtask

  task automatic test_commit();
    do_reset();
    drive(2'b01, 32'h8000_0006, 6, 32'h0, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 0);
    tick();
    commit_val = 1; commit_seq_num = 5'd6;
    tick();
    commit_val = 0;
    checks++;
    if (dut.act !== 1'b0) begin
      errors++; $display("FAIL commit_clear got act=%0b want 0", dut.act);
    end
    drive(2'b01, 32'h8000_0009, 9, 32'h0, 0, 0);
    tick();
    checks++;
    if (out_val !== 1'b1 || out_seq_num !== 5'd9) begin
      errors++;
      $display("FAIL commit_emit got v=%0b s=%0d want v=1 s=9",
               out_val, out_seq_num);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    drive(2'b01, 32'h9000_0006, 6, 32'h0, 0, 0);
    tick();
    rst = 1;
    drive(2'b11, 32'h9000_0001, 1, 32'h9000_0002, 2, 0);
    tick();
    rst = 0;
    checks++;
    if (out_val !== 1'b0 || out_seq_num !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%0b s=%0d want v=0 s=0",
               out_val, out_seq_num);
    end
`ifdef SQUASH_ARBITER_FILTER_EN
    checks++;
    if (dut.act !== 1'b0) begin
      errors++; $display("FAIL mid_reset_act got %0b want 0", dut.act);
    end
`endif
    drive(2'b01, 32'h9000_0009, 9, 32'h0, 0, 0);
    tick();
    checks++;
    if (out_val !== 1'b1 || out_seq_num !== 5'd9
        || out_target !== 32'h9000_0009) begin
      errors++;
      $display("FAIL post_reset got v=%0b s=%0d t=%h want v=1 s=9 t=90000009",
               out_val, out_seq_num, out_target);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      in_val = NU'($urandom);
      in_target = {$urandom, $urandom};
      in_seq_num = (SW*NU)'($urandom);
      head_seq_num = SW'($urandom);
      commit_val = 1'($urandom);
      commit_seq_num = $urandom_range(0, 1) ? m_act_seq : SW'($urandom);
      tick();
      checks++;
      if (out_val !== m_val || out_seq_num !== m_seq
          || out_target !== m_tgt) begin
        errors++;
        $display("FAIL random[%0d] got v=%0b s=%0d t=%h want v=%0b s=%0d t=%h",
                 n, out_val, out_seq_num, out_target, m_val, m_seq, m_tgt);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    in_val = '0;
    in_target = '0;
    in_seq_num = '0;
    head_seq_num = '0;
    commit_val = 0;
    commit_seq_num = '0;
    m_val = 0; m_tgt = '0; m_seq = '0;
    m_act = 0; m_act_seq = '0;
    #1;
    test_reset();
    test_oldest();
    test_wrap();
    test_tie();
    test_hold();
`ifdef SQUASH_ARBITER_FILTER_EN
    test_filter();
    test_commit();
`endif
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
